sub16_serial: RTL and testbench

SUB16_SERIAL -- requirements
Module: sub16_serial

---
 rtl/sub16_serial.sv | 161 ++++++++++++++++
 tb/tb_sub16_serial.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub16_serial.sv
// sub16_serial: 16-bit subtractor that works one nibble per clock.
// It computes in1 + ~in2 + 1 over four cycles using a 4-bit carry-lookahead
// slice. diff and the flags are updated together, only when the last nibble
// is done.
module sub16_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] diff,
    output logic        borrow,
    output logic        sign,
    output logic        zero,
    output logic        parity,
    output logic        overflow
);

    localparam int unsigned W     = 16;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Generate/propagate lookahead over one nibble; returns {carry_out, sum}
    function automatic logic [NIB_W:0] cla4(
        input logic [NIB_W-1:0] a,
        input logic [NIB_W-1:0] b,
        input logic             cin
    );
        logic [NIB_W-1:0] g;
        logic [NIB_W-1:0] p;
        logic [NIB_W:0]   c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[NIB_W-1:0]};
    endfunction

    state_t             state_q;
    logic [W-1:0]       a_q;        // minuend, shifted right one nibble per RUN edge
    logic [W-1:0]       b_q;        // subtrahend, shifted the same way
    logic [W-1:0]       shadow_q;   // result nibbles, shifted in from the top
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [W-1:0]       diff_q;
    logic               borrow_q;
    logic               sign_q;
    logic               zero_q;
    logic               parity_q;
    logic               overflow_q;

    logic [NIB_W:0]     slice_d;
    logic [NIB_W-1:0]   sum_d;
    logic               cout_d;
    logic [W-1:0]       diff_d;
    logic               ovf_d;

    // Current nibble of in1 + ~in2 + carry; on the last nibble a_q/b_q[3] hold the operand MSBs
    always_comb begin
        slice_d = cla4(a_q[NIB_W-1:0], ~b_q[NIB_W-1:0], carry_q);
        sum_d   = slice_d[NIB_W-1:0];
        cout_d  = slice_d[NIB_W];
        diff_d  = {sum_d, shadow_q[W-1:NIB_W]};
        ovf_d   = (a_q[NIB_W-1] != b_q[NIB_W-1]) && (diff_d[W-1] != a_q[NIB_W-1]);
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            shadow_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
            parity_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        shadow_q <= '0;
                        cnt_q    <= '0;
                        carry_q  <= 1'b1;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= {{NIB_W{1'b0}}, a_q[W-1:NIB_W]};
                    b_q      <= {{NIB_W{1'b0}}, b_q[W-1:NIB_W]};
                    shadow_q <= diff_d;
                    carry_q  <= cout_d;
                    cnt_q    <= CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_q == CNT_W'(3)) begin
                        diff_q     <= diff_d;
                        borrow_q   <= ~cout_d;
                        sign_q     <= diff_d[W-1];
                        zero_q     <= (diff_d == '0);
                        parity_q   <= ~(^diff_d);
                        overflow_q <= ovf_d;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign sign     = sign_q;
    assign zero     = zero_q;
    assign parity   = parity_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Directed testbench for sub16_serial. The expected values below are worked out by hand.
// Flag vectors are packed as {borrow, sign, zero, parity, overflow}.
module tb_sub16_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        borrow;
    logic        sign;
    logic        zero;
    logic        parity;
    logic        overflow;

    int checks;
    int failures;

    sub16_serial dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .sign     (sign),
        .zero     (zero),
        .parity   (parity),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from IDLE and report latency, result and flags.
    // The operands are scrambled after the accepting edge.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          output int lat, output logic [15:0] d,
                          output logic [4:0] f, output logic done_next);
        in1 = x; in2 = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in1 = ~x; in2 = x ^ 16'h5A3C;
        lat = -1;
        d = 16'hxxxx;
        f = 5'bxxxxx;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                d = diff;
                f = {borrow, sign, zero, parity, overflow};
                break;
            end
        end
        @(posedge clk); #1;
        done_next = done;
    endtask

    task automatic test_reset();
        logic [4:0] f;
        rst = 1'b1; start = 1'b0; in1 = 16'h0; in2 = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        f = {borrow, sign, zero, parity, overflow};
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl: {ready,busy,done}=%b required 100", {ready, busy, done});
        end
        checks++;
        if (diff !== 16'h0000 || f !== 5'b00000) begin
            failures++;
            $display("FAIL reset_data: diff=%h flags=%b required 0000/00000", diff, f);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_handshake();
        in1 = 16'h1234; in2 = 16'h0234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({ready, busy} !== 2'b01) begin
            failures++;
            $display("FAIL run_status: {ready,busy}=%b required 01", {ready, busy});
        end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL early_done cycle %0d: done=%b busy=%b required 0/1", i, done, busy);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({ready, busy, done} !== 3'b011) begin
            failures++;
            $display("FAIL done_status: {ready,busy,done}=%b required 011", {ready, busy, done});
        end
        checks++;
        if (diff !== 16'h1000 || {borrow, sign, zero, parity, overflow} !== 5'b00000) begin
            failures++;
            $display("FAIL basic_result: diff=%h flags=%b required 1000/00000",
                     diff, {borrow, sign, zero, parity, overflow});
        end
        @(posedge clk); #1;
        checks++;
        if ({ready, busy, done} !== 3'b100 || diff !== 16'h1000) begin
            failures++;
            $display("FAIL after_done: {ready,busy,done}=%b diff=%h required 100/1000",
                     {ready, busy, done}, diff);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] xs [8];
        logic [15:0] ys [8];
        logic [15:0] ds [8];
        logic [4:0]  fs [8];
        int          lat;
        logic [15:0] d;
        logic [4:0]  f;
        logic        dn;
        xs[0] = 16'h1234; ys[0] = 16'h0234; ds[0] = 16'h1000; fs[0] = 5'b00000;
        xs[1] = 16'h0000; ys[1] = 16'h0001; ds[1] = 16'hFFFF; fs[1] = 5'b11010;
        xs[2] = 16'h8000; ys[2] = 16'h0001; ds[2] = 16'h7FFF; fs[2] = 5'b00001;
        xs[3] = 16'h7FFF; ys[3] = 16'hFFFF; ds[3] = 16'h8000; fs[3] = 5'b11001;
        xs[4] = 16'h5A5A; ys[4] = 16'h5A5A; ds[4] = 16'h0000; fs[4] = 5'b00110;
        xs[5] = 16'h1000; ys[5] = 16'h0001; ds[5] = 16'h0FFF; fs[5] = 5'b00010;
        xs[6] = 16'hFFFF; ys[6] = 16'h0000; ds[6] = 16'hFFFF; fs[6] = 5'b01010;
        xs[7] = 16'h0003; ys[7] = 16'h0005; ds[7] = 16'hFFFE; fs[7] = 5'b11000;
        for (int k = 0; k < 8; k++) begin
            run_op(xs[k], ys[k], lat, d, f, dn);
            checks++;
            if (lat != 4) begin
                failures++;
                $display("FAIL latency vec%0d: got %0d required 4", k, lat);
            end
            checks++;
            if (d !== ds[k] || f !== fs[k]) begin
                failures++;
                $display("FAIL result vec%0d %h-%h: diff=%h flags=%b required %h/%b",
                         k, xs[k], ys[k], d, f, ds[k], fs[k]);
            end
            checks++;
            if (dn !== 1'b0) begin
                failures++;
                $display("FAIL done_width vec%0d: done=%b after pulse required 0", k, dn);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n_done;
        int first;
        n_done = 0;
        first = -1;
        in1 = 16'h0010; in2 = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in1 = 16'hFFFF; in2 = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (n_done != 1 || first != 4) begin
            failures++;
            $display("FAIL ignore_start: done pulses=%0d first=%0d required 1 at 4", n_done, first);
        end
        checks++;
        if (diff !== 16'h000F || {borrow, sign, zero, parity, overflow} !== 5'b00010) begin
            failures++;
            $display("FAIL ignore_result: diff=%h flags=%b required 000F/00010",
                     diff, {borrow, sign, zero, parity, overflow});
        end
    endtask

    task automatic test_reset_abort();
        int          n_done;
        int          lat;
        logic [15:0] d;
        logic [4:0]  f;
        logic        dn;
        n_done = 0;
        in1 = 16'h1234; in2 = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done} !== 3'b100 || diff !== 16'h0000 ||
            {borrow, sign, zero, parity, overflow} !== 5'b00000) begin
            failures++;
            $display("FAIL async_reset: {ready,busy,done}=%b diff=%h flags=%b required 100/0000/00000",
                     {ready, busy, done}, diff, {borrow, sign, zero, parity, overflow});
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL abort_no_done: done pulses=%0d required 0", n_done);
        end
        run_op(16'h0003, 16'h0005, lat, d, f, dn);
        checks++;
        if (lat != 4 || d !== 16'hFFFE || f[4] !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_op: lat=%0d diff=%h borrow=%b required 4/FFFE/1", lat, d, f[4]);
        end
    endtask

    task automatic test_back_to_back();
        int          first;
        int          second;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b2;
        logic        rdy5;
        logic        rdy6;
        first = -1; second = -1;
        d1 = 16'h0; d2 = 16'h0; b2 = 1'b0; rdy5 = 1'b0; rdy6 = 1'b1;
        in1 = 16'h0100; in2 = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        in1 = 16'h0002; in2 = 16'h0004;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk); #1;
            if (i == 5) rdy5 = ready;
            if (i == 6) rdy6 = ready;
            if (i == 7) start = 1'b0;
            if (done) begin
                if (first < 0) begin
                    first = i; d1 = diff;
                end else if (second < 0) begin
                    second = i; d2 = diff; b2 = borrow;
                end
            end
        end
        checks++;
        if (first != 4 || second != 10) begin
            failures++;
            $display("FAIL b2b_timing: done at %0d and %0d required 4 and 10", first, second);
        end
        checks++;
        if (d1 !== 16'h00FF || d2 !== 16'hFFFE || b2 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_results: %h %h borrow=%b required 00FF FFFE 1", d1, d2, b2);
        end
        checks++;
        if (rdy5 !== 1'b1 || rdy6 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready: ready@5=%b ready@6=%b required 1/0", rdy5, rdy6);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_handshake();
        test_vectors();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
